sr_excitation_gen: RTL and testbench

SR_EXCITATION_GEN -- requirements
Module: sr_excitation_gen

---
 rtl/sr_exc_pkg.sv | 30 +++
 rtl/sr_exc_fifo.sv | 61 ++++++
 rtl/sr_excitation_gen.sv | 154 +++++++++++++++
 tb/tb_sr_excitation_gen.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_exc_pkg.sv
// Shared types and constants for the SR flip-flop excitation generator.
// Optional feedback checker in the top is enabled by defining SR_EXC_CHECK_EN.
package sr_exc_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_RST  = 2'b01;
    localparam logic [1:0] SR_SET  = 2'b10;
    localparam logic [1:0] SR_INV  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } sr_state_e;

    // Code that moves an SR flop from q to target; never yields SR_INV.
    function automatic logic [1:0] exc_code(input logic q, input logic target);
        if (!q && target) begin
            return SR_SET;
        end else if (q && !target) begin
            return SR_RST;
        end else begin
            return SR_HOLD;
        end
    endfunction

endpackage

// File: rtl/sr_exc_fifo.sv
// Single-bit FIFO holding target bits; DEPTH must be a power of two so the
// pointers wrap naturally.
module sr_exc_fifo
    import sr_exc_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  logic i_pop,
    input  logic i_din,
    output logic o_dout,
    output logic o_full,
    output logic o_empty
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic                r_mem [0:DEPTH-1];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W:0]      r_count;
    logic                w_push_ok;
    logic                w_pop_ok;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_dout    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

endmodule

// File: rtl/sr_excitation_gen.sv
// Turns a stream of desired Q values into registered {S,R} codes for an SR flop.
// Define SR_EXC_CHECK_EN to add a CHECK state comparing q_fb against the model.
module sr_excitation_gen
    import sr_exc_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic [1:0]       sr,
    input  logic             q_fb,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    sr_state_e  r_state;
    sr_state_e  w_state_nxt;
    logic [1:0] r_sr;
    logic [1:0] w_sr_nxt;
    logic       r_q_model;
    logic       w_q_model_nxt;
    logic       r_target;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic       w_head;

    assign in_ready = !w_full && !rst;
    assign w_push   = in_valid && in_ready;
    assign busy     = !w_empty || (r_state != ST_IDLE);
    assign sr       = r_sr;

    sr_exc_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_push),
        .i_pop  (w_pop),
        .i_din  (in_bit),
        .o_dout (w_head),
        .o_full (w_full),
        .o_empty(w_empty)
    );

`ifdef SR_EXC_CHECK_EN
    logic             w_mismatch;
    logic             r_err;
    logic [CNT_W-1:0] r_err_cnt;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_sr_nxt      = SR_HOLD;
        w_q_model_nxt = r_q_model;
        w_pop         = 1'b0;
`ifdef SR_EXC_CHECK_EN
        w_mismatch    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_DRIVE;
                    w_sr_nxt    = exc_code(r_q_model, w_head);
                end
            end
            ST_DRIVE: begin
                // The flop takes the target at the edge leaving DRIVE.
                w_q_model_nxt = r_target;
`ifdef SR_EXC_CHECK_EN
                w_state_nxt   = ST_CHECK;
`else
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_DRIVE;
                    w_sr_nxt    = exc_code(r_target, w_head);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
`endif
            end
`ifdef SR_EXC_CHECK_EN
            ST_CHECK: begin
                w_mismatch = (q_fb != r_q_model);
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_DRIVE;
                    w_sr_nxt    = exc_code(r_q_model, w_head);
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sr      <= SR_HOLD;
            r_q_model <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sr      <= w_sr_nxt;
            r_q_model <= w_q_model_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_target <= w_head;
        end
    end

`ifdef SR_EXC_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_mismatch) begin
            r_err <= 1'b1;
            if (r_err_cnt != {CNT_W{1'b1}}) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign err     = r_err;
    assign err_cnt = r_err_cnt;
`else
    logic w_unused_q_fb;

    assign w_unused_q_fb = q_fb;
    assign err           = 1'b0;
    assign err_cnt       = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (r_sr != SR_INV);
        end
    end

endmodule

// File: tb/tb_sr_excitation_gen.sv
// Scoreboard bench for sr_excitation_gen; expected codes come from a behavioural
// model of the SR flop transitions, checked by an independent monitor.
module tb_sr_excitation_gen;
    import sr_exc_pkg::*;

`ifdef SR_EXC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] code;
        logic       tgt;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic [1:0] sr;
    logic       q_fb;
    logic       busy;
    logic       err;
    logic [7:0] err_cnt;

    logic       s_valid;
    logic       s_bit;
    logic       s_ready;
    logic [1:0] s_sr;
    logic       s_busy;
    logic       s_err;
    logic [1:0] s_cnt;

    logic       f_push;
    logic       f_pop;
    logic       f_din;
    logic       f_dout;
    logic       f_full;
    logic       f_empty;

    logic       stuck;
    logic       flop_q;
    logic       model_q;
    logic       pend_v;
    logic       pend_t;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         n_inv = 0;
    int         cyc = 0;
    exp_t       exp_q[$];
    logic       fq[$];
    logic [1:0] tr_sr   [0:4095];
    logic       tr_busy [0:4095];

    sr_excitation_gen dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_bit  (in_bit),
        .in_ready(in_ready),
        .sr      (sr),
        .q_fb    (q_fb),
        .busy    (busy),
        .err     (err),
        .err_cnt (err_cnt)
    );

    sr_excitation_gen #(.DEPTH(4), .CNT_W(2)) dut_s (
        .clk     (clk),
        .rst     (rst),
        .in_valid(s_valid),
        .in_bit  (s_bit),
        .in_ready(s_ready),
        .sr      (s_sr),
        .q_fb    (1'b0),
        .busy    (s_busy),
        .err     (s_err),
        .err_cnt (s_cnt)
    );

    sr_exc_fifo #(.DEPTH(4)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .i_push (f_push),
        .i_pop  (f_pop),
        .i_din  (f_din),
        .o_dout (f_dout),
        .o_full (f_full),
        .o_empty(f_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream SR flop, sharing the block's reset.
    always @(posedge clk) begin
        if (rst) flop_q <= 1'b0;
        else if (sr == 2'b10) flop_q <= 1'b1;
        else if (sr == 2'b01) flop_q <= 1'b0;
    end
    assign q_fb = stuck ? 1'b0 : flop_q;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < 4096) begin
            tr_sr[cyc]   <= sr;
            tr_busy[cyc] <= busy;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [1:0] ref_code(input logic q, input logic t);
        if (t == q) return 2'b00;
        return t ? 2'b10 : 2'b01;
    endfunction

    task automatic model_push(input logic b);
        logic [1:0] c;
        c = ref_code(model_q, b);
        if (c != 2'b00) exp_q.push_back('{code: c, tgt: b});
        model_q = b;
    endtask

    task automatic push_bit(input logic b);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_bit   = b;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("push_timeout", 32'(in_ready), 1);
        else model_push(b);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int w;
        w = 0;
        while (busy && w < 60) begin
            @(posedge clk);
            #1;
            w++;
        end
        check({nm, "_idle"}, 32'(busy), 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        exp_q.delete();
        model_q = 1'b0;
        #1;
    endtask

    task automatic fstep(input logic p, input logic q, input logic d);
        bit do_push;
        bit do_pop;
        f_push = p;
        f_pop  = q;
        f_din  = d;
        do_pop  = q && (fq.size() > 0);
        do_push = p && (fq.size() < 4);
        @(negedge clk);
        check("fifo_full_pre", 32'(f_full), 32'(fq.size() == 4));
        if (do_pop) check("fifo_dout", 32'(f_dout), 32'(fq[0]));
        @(posedge clk);
        #1;
        f_push = 1'b0;
        f_pop  = 1'b0;
        if (do_pop) void'(fq.pop_front());
        if (do_push) fq.push_back(d);
        check("fifo_full", 32'(f_full), 32'(fq.size() == 4));
        check("fifo_empty", 32'(f_empty), 32'(fq.size() == 0));
    endtask

    // Monitor: every non-hold code must match the next expected transition.
    initial begin : monitor
        exp_t e;
        pend_v = 1'b0;
        forever begin
            @(negedge clk);
            if (sr === 2'b11 || s_sr === 2'b11) n_inv++;
            if (rst) begin
                pend_v = 1'b0;
            end else begin
                if (pend_v) begin
                    check("flop_q_after_code", 32'(flop_q), 32'(pend_t));
                    pend_v = 1'b0;
                end
                if (sr !== SR_HOLD) begin
                    if (exp_q.size() == 0) begin
                        check("sr_unexpected", 32'(sr), 32'(SR_HOLD));
                    end else begin
                        e = exp_q.pop_front();
                        check("sr_code", 32'(sr), 32'(e.code));
                        pend_v = 1'b1;
                        pend_t = e.tgt;
                    end
                end
            end
        end
    end

    initial begin : stim
        logic       seq_a[$];
        logic [1:0] exp_a[$];
        logic       seq_c[$];
        logic       fs[$];
        int         c0;
        int         c1;
        int         lastb;
        int         nz;
        int         acc;
        int         w;
        bit         hit;

        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; stuck = 1'b0; model_q = 1'b0;
        s_valid = 1'b0; s_bit = 1'b0; f_push = 1'b0; f_pop = 1'b0; f_din = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("reset_sr", 32'(sr), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_in_ready", 32'(in_ready), 0);
        check("reset_err", 32'(err), 0);
        check("reset_err_cnt", 32'(err_cnt), 0);
        check("reset_fifo_empty", 32'(f_empty), 1);
        rst = 1'b0;
        #1;
        check("ready_after_reset", 32'(in_ready), 1);

        // Back-to-back directed stream with cycle-exact sr and busy trace.
        if (CHK) begin
            seq_a = '{1'b1, 1'b0, 1'b0, 1'b1};
            exp_a = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
            lastb = 8;
        end else begin
            seq_a = '{1'b1, 1'b0, 1'b1};
            exp_a = '{2'b00, 2'b10, 2'b01, 2'b10, 2'b00};
            lastb = 3;
        end
        c0 = cyc + 1;
        foreach (seq_a[i]) begin
            in_valid = 1'b1;
            in_bit   = seq_a[i];
            @(negedge clk);
            check("dir_in_ready", 32'(in_ready), 1);
            model_push(seq_a[i]);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        foreach (exp_a[k]) check($sformatf("dir_sr_cycle%0d", k), 32'(tr_sr[c0+k]), 32'(exp_a[k]));
        check("dir_busy_last", 32'(tr_busy[c0+lastb]), 1);
        check("dir_busy_fall", 32'(tr_busy[c0+lastb+1]), 0);
        check("dir_err", 32'(err), 0);
        check("dir_queue_drained", exp_q.size(), 0);

        // FIFO ordering, full/ready timing and simultaneous push/pop.
        fs = '{1,0,1, 1,0,0, 1,0,1, 1,0,1, 1,0,0, 0,1,0, 1,1,0, 1,0,1,
               0,1,0, 0,1,0, 0,1,0, 0,1,0, 0,1,0};
        for (int i = 0; i < fs.size(); i += 3) fstep(fs[i], fs[i+1], fs[i+2]);

        // Reset during a set code with bits still queued.
        seq_c = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        hit = 1'b0;
        foreach (seq_c[i]) begin
            if (!hit) begin
                in_valid = 1'b1;
                in_bit   = seq_c[i];
                @(negedge clk);
                if (in_ready) model_push(seq_c[i]);
                @(posedge clk);
                #1;
                if (sr == 2'b10) hit = 1'b1;
            end
        end
        check("rst_drive_seen", 32'(hit), 1);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_sr", 32'(sr), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_in_ready", 32'(in_ready), 0);
        rst = 1'b0;
        exp_q.delete();
        model_q = 1'b0;
        #1;
        check("rst_mid_ready_after", 32'(in_ready), 1);
        c1 = cyc + 1;
        push_bit(1'b0);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        nz = 0;
        for (int k = 0; k < 6; k++) if (tr_sr[c1+k] != 2'b00) nz++;
        check("rst_then_zero_codes", nz, 0);
        check("rst_then_idle", 32'(busy), 0);

        // Feedback stuck low.
        stuck = 1'b1;
        push_bit(1'b1);
        push_bit(1'b1);
        wait_idle("stuck");
        check("stuck_err", 32'(err), CHK ? 1 : 0);
        check("stuck_err_cnt", 32'(err_cnt), CHK ? 2 : 0);
        stuck = 1'b0;
        pulse_reset();
        check("err_cleared", 32'(err), 0);

        // Saturation on the narrow-counter instance.
        s_valid = 1'b1;
        s_bit   = 1'b1;
        acc = 0;
        w = 0;
        while (acc < 5 && w < 100) begin
            @(negedge clk);
            if (s_ready) acc++;
            @(posedge clk);
            #1;
            w++;
        end
        s_valid = 1'b0;
        check("sat_accepted", acc, 5);
        w = 0;
        while (s_busy && w < 40) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("sat_idle", 32'(s_busy), 0);
        check("sat_err", 32'(s_err), CHK ? 1 : 0);
        check("sat_err_cnt", 32'(s_cnt), CHK ? 3 : 0);

        // Random stream with the behavioural flop closing the loop.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            push_bit(1'($urandom_range(0, 1)));
        end
        wait_idle("rand");
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rand_err", 32'(err), 0);
        check("rand_err_cnt", 32'(err_cnt), 0);
        check("rand_queue_drained", exp_q.size(), 0);
        check("rand_final_q", 32'(flop_q), 32'(model_q));
        check("sr_never_11", n_inv, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
